rs_alu: RTL and testbench
=========================

Name: rs_alu

Overview:
- Reservation station for the integer ALU, directly upstream of the ALU.
- Buffers up to RS_DEPTH dispatched ALU ops and captures operand values broadcast on the two CDB ports (ALU result, load/store result).
- Each cycle it issues one op whose operands are both ready, through registered outputs, into the combinational ALU.
- Flushes completely on a branch/jump redirect.

Parameters:
- RS_DEPTH, 8, number of entries (power of two, 2..16).
- DATA_W, 32, operand/data width.
- TAG_W, 4, ROB tag width.
- NAME_W, 5, architectural register name width.
- OP_W, 6, opcode width.
- ADDR_W, 32, instruction address width.
- TAG_FREE, {TAG_W{1'b1}}, tag value meaning "operand already valid".

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- clearEn  in  1  flush (jump/mispredict); kills all entries.
- allocEn  in  1  dispatch request.
- allocOpO, allocOpT  in  DATA_W  operand values (meaningful only when the matching tag is TAG_FREE).
- allocTagO, allocTagT  in  TAG_W  producer ROB tags, or TAG_FREE.
- allocWrtTag  in  TAG_W  destination ROB tag.
- allocWrtName  in  NAME_W  destination register name.
- allocOpCode  in  OP_W  ALU opcode.
- allocInstAddr  in  ADDR_W  instruction PC.
- rsFull  out  1  no free entry (combinational from state).
- cdbAluEn, cdbLsEn  in  1  broadcast valid.
- cdbAluTag, cdbLsTag  in  TAG_W  broadcast tags.
- cdbAluData, cdbLsData  in  DATA_W  broadcast data.
- ALUworkEn  out  1  issue valid.
- operandO, operandT  out  DATA_W  issued operands.
- wrtTag  out  TAG_W  issued destination tag.
- wrtName  out  NAME_W  issued destination name.
- opCode  out  OP_W  issued opcode.
- instAddr  out  ADDR_W  issued PC.

Behaviour:
- Entry state: valid, opO, tagO, opT, tagT, wrtTag, wrtName, opCode, instAddr. An entry is ready when valid, tagO==TAG_FREE and tagT==TAG_FREE.
- Reset (rst low, asynchronous):
  - All valid bits cleared.
  - ALUworkEn=0, operandO/operandT=0, wrtTag=TAG_FREE, wrtName=0, opCode=0, instAddr=0.
  - rsFull=0 immediately after reset.
- Allocation:
  - When allocEn && !rsFull && !clearEn, the lowest-index free entry is written at the edge.
  - allocEn while rsFull is ignored, with no state change; the decoder must hold the op.
- Wake-up:
  - At each edge, every valid entry whose tagX equals an enabled CDB tag loads that CDB data and sets tagX=TAG_FREE. The ALU port is checked first, then the LS port; the two tags are never equal by construction.
  - Dispatch bypass: allocation tags are compared against both CDB ports in the same cycle, and a matching operand is stored already resolved. No wake-up is lost at the allocation edge.
- Select/issue:
  - Combinational select over stored state picks the lowest-index ready entry.
  - At the edge, its fields are registered onto the outputs, ALUworkEn=1, and the entry is freed.
  - With no ready entry, ALUworkEn=0 and the other outputs hold their last values.
- Latency:
  - An op allocated with both operands free at edge E0 issues at edge E1, so ALUworkEn is high in the cycle after E1.
  - The same applies to an entry woken at edge E0.
  - Minimum of one dispatch-to-issue bubble.
- Throughput: one issue and one allocation per cycle. Issue and allocation on the same edge are legal. When full, the entry freed by issue is not reusable on that same edge.
- Flush: clearEn at an edge clears all valid bits and forces ALUworkEn=0. It takes priority over allocation, wake-up and issue. rsFull drops in the following cycle.
- Reset mid-operation discards all entries and any pending issue with no further output.
- rsFull = all RS_DEPTH valid bits set.

Optional Feature:
- Macro: RS_AGE_SELECT_EN.
- Defined:
  - Each entry holds a log2(RS_DEPTH)-bit age. It is set to 0 on allocation, and all other valid entries increment their age on each allocation (saturating).
  - Select picks the ready entry with the greatest age, giving oldest-first issue. Ties go to the lowest index.
- Undefined: no age state; select is lowest-index ready, exactly as specified above.

Test Plan:
- Reset, then dispatch ADD with opO=5, opT=7, both tags TAG_FREE, wrtTag=3 -> ALUworkEn=1 with operandO=5, operandT=7, wrtTag=3 two cycles after allocEn; rsFull=0 throughout.
- Dispatch with tagO=2 unresolved, then cdbLsEn with tag 2, data 0x1234 three cycles later -> issue occurs one cycle after the broadcast edge with operandO=0x1234.
- allocEn with tagT=6 in the same cycle as cdbAluEn tag 6, data 0xFFFF_FFFF -> entry is ready at once and issues the next cycle with operandT=0xFFFF_FFFF.
- Fill all 8 entries with unresolved tags -> rsFull=1. A ninth allocEn is ignored. Broadcast the tag held by entry 5 -> only entry 5 issues and rsFull clears the cycle after.
- Four ready entries queued, assert clearEn for one cycle -> ALUworkEn=0 the next cycle, no further issues, rsFull=0, a fresh dispatch issues normally.
- With RS_AGE_SELECT_EN: allocate to index 1 while blocked, then to index 0 after index 0 is freed, then wake both at the same edge -> index 1 (older) issues first. Without the macro, index 0 issues first.

Source files
------------

// File: rtl/rs_alu.sv
// Integer-ALU reservation station: buffers dispatched ops, captures CDB results, issues one ready op per cycle.
// Optional macro RS_AGE_SELECT_EN switches select from lowest-index-ready to oldest-ready.
module rs_alu #(
  parameter int               RS_DEPTH = 8,
  parameter int               DATA_W   = 32,
  parameter int               TAG_W    = 4,
  parameter int               NAME_W   = 5,
  parameter int               OP_W     = 6,
  parameter int               ADDR_W   = 32,
  parameter logic [TAG_W-1:0] TAG_FREE = {TAG_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clearEn,
  input  logic              allocEn,
  input  logic [DATA_W-1:0] allocOpO,
  input  logic [DATA_W-1:0] allocOpT,
  input  logic [TAG_W-1:0]  allocTagO,
  input  logic [TAG_W-1:0]  allocTagT,
  input  logic [TAG_W-1:0]  allocWrtTag,
  input  logic [NAME_W-1:0] allocWrtName,
  input  logic [OP_W-1:0]   allocOpCode,
  input  logic [ADDR_W-1:0] allocInstAddr,
  output logic              rsFull,
  input  logic              cdbAluEn,
  input  logic [TAG_W-1:0]  cdbAluTag,
  input  logic [DATA_W-1:0] cdbAluData,
  input  logic              cdbLsEn,
  input  logic [TAG_W-1:0]  cdbLsTag,
  input  logic [DATA_W-1:0] cdbLsData,
  output logic              ALUworkEn,
  output logic [DATA_W-1:0] operandO,
  output logic [DATA_W-1:0] operandT,
  output logic [TAG_W-1:0]  wrtTag,
  output logic [NAME_W-1:0] wrtName,
  output logic [OP_W-1:0]   opCode,
  output logic [ADDR_W-1:0] instAddr
);

  localparam int IDX_W = $clog2(RS_DEPTH);

  logic [RS_DEPTH-1:0] vld_p0;
  logic [DATA_W-1:0]   opo_p0   [RS_DEPTH];
  logic [DATA_W-1:0]   opt_p0   [RS_DEPTH];
  logic [TAG_W-1:0]    tago_p0  [RS_DEPTH];
  logic [TAG_W-1:0]    tagt_p0  [RS_DEPTH];
  logic [TAG_W-1:0]    wtag_p0  [RS_DEPTH];
  logic [NAME_W-1:0]   wname_p0 [RS_DEPTH];
  logic [OP_W-1:0]     opc_p0   [RS_DEPTH];
  logic [ADDR_W-1:0]   pc_p0    [RS_DEPTH];

  logic [RS_DEPTH-1:0] rdy;
  logic [IDX_W-1:0]    free_idx;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_vld;
  logic                alloc_go;
  logic [DATA_W-1:0]   new_opo;
  logic [DATA_W-1:0]   new_opt;
  logic [TAG_W-1:0]    new_tago;
  logic [TAG_W-1:0]    new_tagt;

  // A stored TAG_FREE never matches, so a CDB tag equal to TAG_FREE cannot clobber a resolved operand.
  function automatic logic cdb_hit(input logic [TAG_W-1:0] tag, input logic en,
                                   input logic [TAG_W-1:0] cdb_tag);
    return en && (tag != TAG_FREE) && (tag == cdb_tag);
  endfunction

`ifdef RS_AGE_SELECT_EN
  logic [IDX_W-1:0] age_p0 [RS_DEPTH];
  logic [IDX_W-1:0] best_age;

  function automatic logic [IDX_W-1:0] age_sat_inc(input logic [IDX_W-1:0] a);
    return (a == {IDX_W{1'b1}}) ? a : a + IDX_W'(1);
  endfunction
`endif

  assign rsFull   = &vld_p0;
  assign alloc_go = allocEn && !rsFull && !clearEn;

  always_comb begin
    rdy = '0;
    for (int i = 0; i < RS_DEPTH; i++)
      rdy[i] = vld_p0[i] && (tago_p0[i] == TAG_FREE) && (tagt_p0[i] == TAG_FREE);
  end

  always_comb begin
    free_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--)
      if (!vld_p0[i]) free_idx = IDX_W'(i);
  end

`ifdef RS_AGE_SELECT_EN
  // Strictly-greater compare keeps the lowest index on equal ages.
  always_comb begin
    sel_idx  = '0;
    sel_vld  = 1'b0;
    best_age = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (rdy[i] && (!sel_vld || (age_p0[i] > best_age))) begin
        sel_vld  = 1'b1;
        sel_idx  = IDX_W'(i);
        best_age = age_p0[i];
      end
    end
  end
`else
  always_comb begin
    sel_idx = '0;
    sel_vld = |rdy;
    for (int i = RS_DEPTH - 1; i >= 0; i--)
      if (rdy[i]) sel_idx = IDX_W'(i);
  end
`endif

  // Dispatch bypass: an operand produced on the CDB this cycle is stored already resolved.
  always_comb begin
    new_opo  = allocOpO;
    new_tago = allocTagO;
    new_opt  = allocOpT;
    new_tagt = allocTagT;
    if (cdb_hit(allocTagO, cdbAluEn, cdbAluTag)) begin
      new_opo  = cdbAluData;
      new_tago = TAG_FREE;
    end else if (cdb_hit(allocTagO, cdbLsEn, cdbLsTag)) begin
      new_opo  = cdbLsData;
      new_tago = TAG_FREE;
    end
    if (cdb_hit(allocTagT, cdbAluEn, cdbAluTag)) begin
      new_opt  = cdbAluData;
      new_tagt = TAG_FREE;
    end else if (cdb_hit(allocTagT, cdbLsEn, cdbLsTag)) begin
      new_opt  = cdbLsData;
      new_tagt = TAG_FREE;
    end
  end

  // Stage p0: entry payload (alloc write and CDB wake-up); meaning is gated by vld_p0.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (alloc_go && (free_idx == IDX_W'(i))) begin
        opo_p0[i]   <= new_opo;
        tago_p0[i]  <= new_tago;
        opt_p0[i]   <= new_opt;
        tagt_p0[i]  <= new_tagt;
        wtag_p0[i]  <= allocWrtTag;
        wname_p0[i] <= allocWrtName;
        opc_p0[i]   <= allocOpCode;
        pc_p0[i]    <= allocInstAddr;
      end else if (vld_p0[i]) begin
        if (cdb_hit(tago_p0[i], cdbAluEn, cdbAluTag)) begin
          opo_p0[i]  <= cdbAluData;
          tago_p0[i] <= TAG_FREE;
        end else if (cdb_hit(tago_p0[i], cdbLsEn, cdbLsTag)) begin
          opo_p0[i]  <= cdbLsData;
          tago_p0[i] <= TAG_FREE;
        end
        if (cdb_hit(tagt_p0[i], cdbAluEn, cdbAluTag)) begin
          opt_p0[i]  <= cdbAluData;
          tagt_p0[i] <= TAG_FREE;
        end else if (cdb_hit(tagt_p0[i], cdbLsEn, cdbLsTag)) begin
          opt_p0[i]  <= cdbLsData;
          tagt_p0[i] <= TAG_FREE;
        end
      end
    end
  end

  // Stage p1: occupancy control and the registered issue port into the ALU.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0    <= '0;
      ALUworkEn <= 1'b0;
      operandO  <= '0;
      operandT  <= '0;
      wrtTag    <= TAG_FREE;
      wrtName   <= '0;
      opCode    <= '0;
      instAddr  <= '0;
`ifdef RS_AGE_SELECT_EN
      for (int i = 0; i < RS_DEPTH; i++) age_p0[i] <= '0;
`endif
    end else if (clearEn) begin
      vld_p0    <= '0;
      ALUworkEn <= 1'b0;
    end else begin
      ALUworkEn <= sel_vld;
      if (sel_vld) begin
        operandO        <= opo_p0[sel_idx];
        operandT        <= opt_p0[sel_idx];
        wrtTag          <= wtag_p0[sel_idx];
        wrtName         <= wname_p0[sel_idx];
        opCode          <= opc_p0[sel_idx];
        instAddr        <= pc_p0[sel_idx];
        vld_p0[sel_idx] <= 1'b0;
      end
      if (alloc_go) vld_p0[free_idx] <= 1'b1;
`ifdef RS_AGE_SELECT_EN
      if (alloc_go) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (free_idx == IDX_W'(i)) age_p0[i] <= '0;
          else if (vld_p0[i])        age_p0[i] <= age_sat_inc(age_p0[i]);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_rs_alu.sv
// Self-checking bench for rs_alu: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_rs_alu;

  localparam int               RS_DEPTH = 8;
  localparam int               DATA_W   = 32;
  localparam int               TAG_W    = 4;
  localparam int               NAME_W   = 5;
  localparam int               OP_W     = 6;
  localparam int               ADDR_W   = 32;
  localparam logic [TAG_W-1:0] TAG_FREE = '1;
  localparam logic [OP_W-1:0]  OP_ADD   = 6'h01;

  logic              clk = 1'b0;
  logic              rst;
  logic              clearEn, allocEn;
  logic [DATA_W-1:0] allocOpO, allocOpT;
  logic [TAG_W-1:0]  allocTagO, allocTagT, allocWrtTag;
  logic [NAME_W-1:0] allocWrtName;
  logic [OP_W-1:0]   allocOpCode;
  logic [ADDR_W-1:0] allocInstAddr;
  logic              rsFull;
  logic              cdbAluEn, cdbLsEn;
  logic [TAG_W-1:0]  cdbAluTag, cdbLsTag;
  logic [DATA_W-1:0] cdbAluData, cdbLsData;
  logic              ALUworkEn;
  logic [DATA_W-1:0] operandO, operandT;
  logic [TAG_W-1:0]  wrtTag;
  logic [NAME_W-1:0] wrtName;
  logic [OP_W-1:0]   opCode;
  logic [ADDR_W-1:0] instAddr;

  rs_alu #(
    .RS_DEPTH(RS_DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .NAME_W(NAME_W),
    .OP_W(OP_W), .ADDR_W(ADDR_W), .TAG_FREE(TAG_FREE)
  ) dut (
    .clk(clk), .rst(rst), .clearEn(clearEn), .allocEn(allocEn),
    .allocOpO(allocOpO), .allocOpT(allocOpT), .allocTagO(allocTagO), .allocTagT(allocTagT),
    .allocWrtTag(allocWrtTag), .allocWrtName(allocWrtName), .allocOpCode(allocOpCode),
    .allocInstAddr(allocInstAddr), .rsFull(rsFull),
    .cdbAluEn(cdbAluEn), .cdbLsEn(cdbLsEn), .cdbAluTag(cdbAluTag), .cdbLsTag(cdbLsTag),
    .cdbAluData(cdbAluData), .cdbLsData(cdbLsData),
    .ALUworkEn(ALUworkEn), .operandO(operandO), .operandT(operandT), .wrtTag(wrtTag),
    .wrtName(wrtName), .opCode(opCode), .instAddr(instAddr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: slots hold pending ops; issue port holds the last issued op.
  typedef struct {
    bit                vld;
    logic [DATA_W-1:0] opo, opt;
    logic [TAG_W-1:0]  tago, tagt, wtag;
    logic [NAME_W-1:0] wname;
    logic [OP_W-1:0]   opc;
    logic [ADDR_W-1:0] pc;
    int                age;
  } ent_t;

  ent_t              m [RS_DEPTH];
  bit                m_en;
  logic [DATA_W-1:0] m_opO, m_opT;
  logic [TAG_W-1:0]  m_wtag;
  logic [NAME_W-1:0] m_wname;
  logic [OP_W-1:0]   m_opc;
  logic [ADDR_W-1:0] m_pc;

  task automatic model_reset();
    for (int i = 0; i < RS_DEPTH; i++) begin
      m[i].vld = 0;
      m[i].age = 0;
    end
    m_en = 0; m_opO = '0; m_opT = '0; m_wtag = TAG_FREE; m_wname = '0; m_opc = '0; m_pc = '0;
  endtask

  function automatic bit model_full();
    for (int i = 0; i < RS_DEPTH; i++) if (!m[i].vld) return 0;
    return 1;
  endfunction

  // Resolve an operand against whatever the two CDB ports carry this cycle.
  function automatic logic [TAG_W+DATA_W-1:0] wake(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    if (t != TAG_FREE && cdbAluEn && t == cdbAluTag) return {TAG_FREE, cdbAluData};
    if (t != TAG_FREE && cdbLsEn && t == cdbLsTag)   return {TAG_FREE, cdbLsData};
    return {t, d};
  endfunction

  task automatic model_edge();
    bit full;
    int slot, sel;
    full = model_full();
    if (clearEn) begin
      for (int i = 0; i < RS_DEPTH; i++) m[i].vld = 0;
      m_en = 0;
      return;
    end
    slot = -1;
    for (int i = RS_DEPTH - 1; i >= 0; i--) if (!m[i].vld) slot = i;
    sel = -1;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (m[i].vld && m[i].tago == TAG_FREE && m[i].tagt == TAG_FREE) begin
`ifdef RS_AGE_SELECT_EN
        if (sel < 0 || m[i].age > m[sel].age) sel = i;
`else
        if (sel < 0) sel = i;
`endif
      end
    end
    if (sel >= 0) begin
      m_en = 1; m_opO = m[sel].opo; m_opT = m[sel].opt; m_wtag = m[sel].wtag;
      m_wname = m[sel].wname; m_opc = m[sel].opc; m_pc = m[sel].pc;
      m[sel].vld = 0;
    end else begin
      m_en = 0;
    end
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (m[i].vld) begin
        {m[i].tago, m[i].opo} = wake(m[i].tago, m[i].opo);
        {m[i].tagt, m[i].opt} = wake(m[i].tagt, m[i].opt);
      end
    end
    if (allocEn && !full) begin
      for (int i = 0; i < RS_DEPTH; i++)
        if (m[i].vld && m[i].age < RS_DEPTH - 1) m[i].age++;
      m[slot].vld = 1;
      m[slot].age = 0;
      {m[slot].tago, m[slot].opo} = wake(allocTagO, allocOpO);
      {m[slot].tagt, m[slot].opt} = wake(allocTagT, allocOpT);
      m[slot].wtag = allocWrtTag; m[slot].wname = allocWrtName;
      m[slot].opc = allocOpCode;  m[slot].pc = allocInstAddr;
    end
  endtask

  task automatic idle_inputs();
    clearEn = 0; allocEn = 0; cdbAluEn = 0; cdbLsEn = 0;
    allocOpO = '0; allocOpT = '0; allocTagO = TAG_FREE; allocTagT = TAG_FREE;
    allocWrtTag = '0; allocWrtName = '0; allocOpCode = '0; allocInstAddr = '0;
    cdbAluTag = '0; cdbLsTag = '0; cdbAluData = '0; cdbLsData = '0;
  endtask

  task automatic alloc(input logic [DATA_W-1:0] o, input logic [TAG_W-1:0] to,
                       input logic [DATA_W-1:0] t, input logic [TAG_W-1:0] tt,
                       input logic [TAG_W-1:0] wt);
    allocEn = 1; allocOpO = o; allocTagO = to; allocOpT = t; allocTagT = tt;
    allocWrtTag = wt; allocWrtName = NAME_W'(wt + 1); allocOpCode = OP_ADD;
    allocInstAddr = 32'h1000 + 32'(wt) * 4;
  endtask

  task automatic tick();
    check("rsFull", 64'(rsFull), 64'(model_full()));
    model_edge();
    @(posedge clk);
    #1;
    check("ALUworkEn", 64'(ALUworkEn), 64'(m_en));
    check("operandO", 64'(operandO), 64'(m_opO));
    check("operandT", 64'(operandT), 64'(m_opT));
    check("wrtTag", 64'(wrtTag), 64'(m_wtag));
    check("wrtName", 64'(wrtName), 64'(m_wname));
    check("opCode", 64'(opCode), 64'(m_opc));
    check("instAddr", 64'(instAddr), 64'(m_pc));
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_en", 64'(ALUworkEn), 64'(0));
    check("rst_wrtTag", 64'(wrtTag), 64'(TAG_FREE));
    check("rst_opO", 64'(operandO), 64'(0));
    check("rst_full", 64'(rsFull), 64'(0));
    rst = 1;

    // Ready-at-dispatch op issues after one bubble.
    alloc(32'd5, TAG_FREE, 32'd7, TAG_FREE, 4'd3);
    tick();
    check("t1_bubble", 64'(ALUworkEn), 64'(0));
    tick();
    check("t1_en", 64'(ALUworkEn), 64'(1));
    check("t1_opO", 64'(operandO), 64'(5));
    check("t1_opT", 64'(operandT), 64'(7));
    check("t1_wtag", 64'(wrtTag), 64'(3));
    check("t1_full", 64'(rsFull), 64'(0));
    tick();
    check("t1_once", 64'(ALUworkEn), 64'(0));

    // Wake-up from the LS port.
    alloc(32'd0, 4'd2, 32'd9, TAG_FREE, 4'd4);
    tick(); tick(); tick();
    check("t2_wait", 64'(ALUworkEn), 64'(0));
    cdbLsEn = 1; cdbLsTag = 4'd2; cdbLsData = 32'h1234;
    tick();
    check("t2_bcast_edge", 64'(ALUworkEn), 64'(0));
    tick();
    check("t2_en", 64'(ALUworkEn), 64'(1));
    check("t2_opO", 64'(operandO), 64'h1234);

    // Dispatch bypass from the ALU port.
    alloc(32'd11, TAG_FREE, 32'd0, 4'd6, 4'd5);
    cdbAluEn = 1; cdbAluTag = 4'd6; cdbAluData = 32'hFFFF_FFFF;
    tick();
    tick();
    check("t3_en", 64'(ALUworkEn), 64'(1));
    check("t3_opT", 64'(operandT), 64'hFFFF_FFFF);

    // Fill, overflow attempt, selective wake of slot 5.
    for (int i = 0; i < RS_DEPTH; i++) begin
      alloc(32'(i), 4'(i), 32'(i + 100), TAG_FREE, 4'(i));
      tick();
    end
    check("t4_full", 64'(rsFull), 64'(1));
    alloc(32'd1, TAG_FREE, 32'd2, TAG_FREE, 4'd12);
    tick();
    check("t4_ignored", 64'(ALUworkEn), 64'(0));
    cdbAluEn = 1; cdbAluTag = 4'd5; cdbAluData = 32'hABCD;
    tick();
    check("t4_still_full", 64'(rsFull), 64'(1));
    tick();
    check("t4_en", 64'(ALUworkEn), 64'(1));
    check("t4_wtag", 64'(wrtTag), 64'(5));
    check("t4_opO", 64'(operandO), 64'hABCD);
    check("t4_not_full", 64'(rsFull), 64'(0));
    tick();
    check("t4_only5", 64'(ALUworkEn), 64'(0));
    clearEn = 1;
    tick();

    // Flush with ready entries queued.
    for (int i = 0; i < 4; i++) begin
      alloc(32'(i + 20), 4'd9, 32'd1, TAG_FREE, 4'(i));
      tick();
    end
    cdbAluEn = 1; cdbAluTag = 4'd9; cdbAluData = 32'h99;
    tick();
    tick();
    check("t5_first", 64'(ALUworkEn), 64'(1));
    clearEn = 1;
    tick();
    check("t5_flush_en", 64'(ALUworkEn), 64'(0));
    tick(); tick();
    check("t5_quiet", 64'(ALUworkEn), 64'(0));
    check("t5_full", 64'(rsFull), 64'(0));
    alloc(32'd40, TAG_FREE, 32'd41, TAG_FREE, 4'd7);
    tick(); tick();
    check("t5_fresh_en", 64'(ALUworkEn), 64'(1));
    check("t5_fresh_opO", 64'(operandO), 64'd40);

    // Age ordering: Y in slot 1 is older than Z later placed in slot 0.
    alloc(32'd1, 4'd10, 32'd0, TAG_FREE, 4'd1); tick();
    alloc(32'd2, 4'd11, 32'd0, TAG_FREE, 4'd2); tick();
    cdbAluEn = 1; cdbAluTag = 4'd10; cdbAluData = 32'h10;
    tick();
    tick();
    check("t6_x", 64'(wrtTag), 64'(1));
    alloc(32'd3, 4'd11, 32'd0, TAG_FREE, 4'd3); tick();
    cdbLsEn = 1; cdbLsTag = 4'd11; cdbLsData = 32'h11;
    tick();
    tick();
`ifdef RS_AGE_SELECT_EN
    check("t6_first", 64'(wrtTag), 64'(2));
`else
    check("t6_first", 64'(wrtTag), 64'(3));
`endif
    tick();
    check("t6_second_en", 64'(ALUworkEn), 64'(1));

    // Asynchronous reset with a pending issue.
    alloc(32'd50, TAG_FREE, 32'd51, TAG_FREE, 4'd8);
    tick();
    #1 rst = 0;
    #1;
    check("t7_rst_en", 64'(ALUworkEn), 64'(0));
    check("t7_rst_wtag", 64'(wrtTag), 64'(TAG_FREE));
    check("t7_rst_opO", 64'(operandO), 64'(0));
    check("t7_rst_full", 64'(rsFull), 64'(0));
    model_reset();
    #2 rst = 1;
    tick();
    check("t7_no_issue", 64'(ALUworkEn), 64'(0));

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 55) begin
        allocEn       = 1;
        allocOpO      = $urandom;
        allocOpT      = $urandom;
        allocTagO     = ($urandom_range(0, 1) == 0) ? TAG_FREE : 4'($urandom_range(0, 6));
        allocTagT     = ($urandom_range(0, 1) == 0) ? TAG_FREE : 4'($urandom_range(0, 6));
        allocWrtTag   = 4'($urandom_range(0, 14));
        allocWrtName  = 5'($urandom);
        allocOpCode   = 6'($urandom);
        allocInstAddr = $urandom;
      end
      cdbAluEn   = ($urandom_range(0, 99) < 40);
      cdbAluTag  = 4'($urandom_range(0, 6));
      cdbAluData = $urandom;
      cdbLsEn    = ($urandom_range(0, 99) < 40);
      cdbLsTag   = 4'($urandom_range(0, 6));
      cdbLsData  = $urandom;
      if (cdbAluEn && cdbLsEn && cdbAluTag == cdbLsTag) cdbLsTag = 4'((cdbAluTag + 1) % 7);
      clearEn    = ($urandom_range(0, 99) < 2);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
